// File: rtl/shift_reg_readback_checker.sv
// Readback checker for a two-phase shift chain: samples sr_out after each phi2
// pulse, compares against a model fed by the driver's d_in/phi1, reports per frame.
module shift_reg_readback_checker #(
  parameter int unsigned CHAIN_LEN    = 3,
  parameter int unsigned SAMPLE_DELAY = 100,
  parameter int unsigned CAPTURE_W    = 16
) (
  input  logic                 clk_in,
  input  logic                 reset,
  input  logic                 frame_active,
  input  logic                 clk_positive,
  input  logic                 clk_negative,
  input  logic                 d_in,
  input  logic                 sr_out,
  output logic [CAPTURE_W-1:0] capture_word,
  output logic [7:0]           bit_count,
  output logic [15:0]          error_count,
  output logic                 result_valid,
  output logic                 pass,
  output logic                 overlap_err,
  output logic                 overflow,
  output logic                 busy
);

  localparam int unsigned DW = $clog2(SAMPLE_DELAY + 1);

  typedef enum logic [2:0] {IDLE, ARMED, DELAY, SAMPLE, DONE} state_e;
  state_e state_q, state_d;

  logic                 sr_meta_q, sr_sync_q;
  logic                 phi1_q, phi2_q, fa_q;
  logic [DW-1:0]        delay_cnt_q, delay_cnt_d;
  logic [CHAIN_LEN-1:0] exp_q, exp_d;
  logic [7:0]           phi1_cnt_q, phi1_cnt_d;
  logic [CAPTURE_W-1:0] cap_q, cap_d;
  logic [7:0]           bc_q, bc_d;
  logic [15:0]          ec_q, ec_d;
  logic                 ovl_q, ovl_d, ovf_q, ovf_d, pass_q, pass_d;

  logic                 phi1_rise, phi2_rise, fa_rise, fa_fall, overlap, pass_now;
  logic [1:0]           err_inc;
  logic [16:0]          ec_sum;

  assign phi1_rise = clk_positive & ~phi1_q;
  assign phi2_rise = clk_negative & ~phi2_q;
  assign fa_rise   = frame_active & ~fa_q;
  assign fa_fall   = ~frame_active & fa_q;
  assign overlap   = clk_positive & clk_negative & (state_q != IDLE);
  assign pass_now  = (ec_q == '0) && (phi1_cnt_q >= 8'(CHAIN_LEN));

  // Edge-detect history is deliberately not reset: a frame already in progress
  // at reset must not look like a fresh frame_active rising edge.
  always_ff @(posedge clk_in) begin
    sr_meta_q <= sr_out;
    sr_sync_q <= sr_meta_q;
    phi1_q    <= clk_positive;
    phi2_q    <= clk_negative;
    fa_q      <= frame_active;
  end

  always_ff @(posedge clk_in) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // SAMPLE also honours a frame end so a fall landing on that cycle is not lost.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (fa_rise) state_d = ARMED;
      ARMED:   if (fa_fall) state_d = DONE;
               else if (phi2_rise) state_d = DELAY;
      DELAY:   if (fa_fall) state_d = DONE;
               else if (!phi2_rise && delay_cnt_q == '0) state_d = SAMPLE;
      SAMPLE:  state_d = fa_fall ? DONE : ARMED;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    delay_cnt_d = delay_cnt_q;
    exp_d       = exp_q;
    phi1_cnt_d  = phi1_cnt_q;
    cap_d       = cap_q;
    bc_d        = bc_q;
    ovl_d       = ovl_q;
    ovf_d       = ovf_q;
    pass_d      = pass_q;
    err_inc     = '0;
    if (state_q == IDLE) begin
      if (fa_rise) begin
        exp_d      = '0;
        phi1_cnt_d = '0;
        cap_d      = '0;
        bc_d       = '0;
        ovl_d      = 1'b0;
        ovf_d      = 1'b0;
        pass_d     = 1'b0;
      end
    end else begin
      if (phi1_rise) begin
        exp_d = {exp_q[CHAIN_LEN-2:0], d_in};
        if (phi1_cnt_q != 8'hFF) phi1_cnt_d = phi1_cnt_q + 8'd1;
      end
      if (overlap) begin
        ovl_d   = 1'b1;
        err_inc = err_inc + 2'd1;
      end
      case (state_q)
        ARMED: if (!fa_fall && phi2_rise) delay_cnt_d = DW'(SAMPLE_DELAY - 1);
        DELAY: if (!fa_fall) begin
          if (phi2_rise) begin
            err_inc     = err_inc + 2'd1;
            delay_cnt_d = DW'(SAMPLE_DELAY - 1);
          end else if (delay_cnt_q != '0) begin
            delay_cnt_d = delay_cnt_q - 1'b1;
          end
        end
        SAMPLE: begin
          if (bc_q < 8'(CAPTURE_W)) begin
            cap_d = {cap_q[CAPTURE_W-2:0], sr_sync_q};
            bc_d  = bc_q + 8'd1;
          end else begin
            ovf_d = 1'b1;
          end
          if (phi1_cnt_q >= 8'(CHAIN_LEN) && sr_sync_q != exp_q[CHAIN_LEN-1])
            err_inc = err_inc + 2'd1;
        end
        DONE:    pass_d = pass_now;
        default: ;
      endcase
    end
    ec_sum = {1'b0, ec_q} + 17'(err_inc);
    ec_d   = ec_sum[16] ? 16'hFFFF : ec_sum[15:0];
    if (state_q == IDLE) ec_d = fa_rise ? '0 : ec_q;
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      delay_cnt_q <= '0;
      exp_q       <= '0;
      phi1_cnt_q  <= '0;
      cap_q       <= '0;
      bc_q        <= '0;
      ec_q        <= '0;
      ovl_q       <= 1'b0;
      ovf_q       <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      delay_cnt_q <= delay_cnt_d;
      exp_q       <= exp_d;
      phi1_cnt_q  <= phi1_cnt_d;
      cap_q       <= cap_d;
      bc_q        <= bc_d;
      ec_q        <= ec_d;
      ovl_q       <= ovl_d;
      ovf_q       <= ovf_d;
      pass_q      <= pass_d;
    end
  end

  always_comb begin
    result_valid = (state_q == DONE);
    busy         = (state_q != IDLE);
    pass         = (state_q == DONE) ? pass_now : pass_q;
    capture_word = cap_q;
    bit_count    = bc_q;
    error_count  = ec_q;
    overlap_err  = ovl_q;
    overflow     = ovf_q;
  end

endmodule

// File: tb/tb_shift_reg_readback_checker.sv
// Directed bench for shift_reg_readback_checker: a behavioural 3-stage chain
// drives sr_out; per-frame expectations go through a scoreboard queue.
module tb_shift_reg_readback_checker;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fa = 1'b0, fa2 = 1'b0;
  logic        clk_positive = 1'b0, clk_negative = 1'b0;
  logic        d_in = 1'b0, sr_out = 1'b0;

  logic [15:0] cw1;
  logic [7:0]  bc1, bc2;
  logic [15:0] ec1, ec2;
  logic        rv1, pass1, ovl1, ovf1, busy1;
  logic [3:0]  cw2;
  logic        rv2, pass2, ovl2, ovf2, busy2;

  int checks = 0;
  int failures = 0;

  logic [2:0] chain = '0;
  bit         stuck = 1'b0;

  typedef struct {
    logic [15:0] cw;
    logic [7:0]  bc;
    logic [15:0] ec;
    logic        pass;
    logic        ovl;
    logic        ovf;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  shift_reg_readback_checker #(.CHAIN_LEN(3), .SAMPLE_DELAY(100), .CAPTURE_W(16)) dut (
    .clk_in(clk), .reset(reset), .frame_active(fa), .clk_positive(clk_positive),
    .clk_negative(clk_negative), .d_in(d_in), .sr_out(sr_out),
    .capture_word(cw1), .bit_count(bc1), .error_count(ec1), .result_valid(rv1),
    .pass(pass1), .overlap_err(ovl1), .overflow(ovf1), .busy(busy1)
  );

  shift_reg_readback_checker #(.CHAIN_LEN(3), .SAMPLE_DELAY(100), .CAPTURE_W(4)) dut_w4 (
    .clk_in(clk), .reset(reset), .frame_active(fa2), .clk_positive(clk_positive),
    .clk_negative(clk_negative), .d_in(d_in), .sr_out(sr_out),
    .capture_word(cw2), .bit_count(bc2), .error_count(ec2), .result_valid(rv2),
    .pass(pass2), .overlap_err(ovl2), .overflow(ovf2), .busy(busy2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic cyc(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input bit which, input exp_t e);
    sb.push_back(e);
    chain  = '0;
    sr_out = 1'b0;
    if (which) fa2 = 1'b1; else fa = 1'b1;
    cyc(3);
  endtask

  // One phi1 pulse then one phi2 pulse; post counts cycles from the phi2 rise.
  task automatic pair(input logic d, input bit ovlp, input int unsigned post);
    d_in = d;
    clk_positive = 1'b1;
    chain = {chain[1:0], d};
    sr_out = stuck ? 1'b0 : chain[2];
    cyc(4);
    d_in = 1'b0;
    if (ovlp) begin
      clk_negative = 1'b1;
      cyc(2);
      clk_positive = 1'b0;
      cyc(2);
    end else begin
      clk_positive = 1'b0;
      cyc(2);
      clk_negative = 1'b1;
      cyc(4);
    end
    clk_negative = 1'b0;
    cyc(post - 4);
  endtask

  task automatic end_frame(input bit which, input string tag);
    exp_t        e;
    int          lat = -1;
    int          nrv = 0;
    logic        rv;
    logic [15:0] cw = '0, ec = '0;
    logic [7:0]  bc = '0;
    logic        ps = 1'b0, ol = 1'b0, of = 1'b0;
    if (which) fa2 = 1'b0; else fa = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      rv = which ? rv2 : rv1;
      if (rv) begin
        nrv++;
        if (lat < 0) begin
          lat = i;
          cw  = which ? {12'h000, cw2} : cw1;
          bc  = which ? bc2 : bc1;
          ec  = which ? ec2 : ec1;
          ps  = which ? pass2 : pass1;
          ol  = which ? ovl2 : ovl1;
          of  = which ? ovf2 : ovf1;
        end
      end
    end
    cyc(1);
    chk({tag, "_rv_latency"}, lat, 2);
    chk({tag, "_rv_pulses"}, nrv, 1);
    if (sb.size() == 0) begin
      chk({tag, "_sb_nonempty"}, 0, 1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_capture_word"}, cw, e.cw);
      chk({tag, "_bit_count"}, bc, e.bc);
      chk({tag, "_error_count"}, ec, e.ec);
      chk({tag, "_pass"}, ps, e.pass);
      chk({tag, "_overlap_err"}, ol, e.ovl);
      chk({tag, "_overflow"}, of, e.ovf);
    end
  endtask

  initial begin
    int nrv;
    cyc(3);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_outputs", {cw1, bc1, ec1, rv1, pass1, ovl1, ovf1}, '0);
    chk("reset_busy", {busy1, busy2}, 2'b00);
    cyc(1);

    // 1: walking one through a correct chain
    start_frame(1'b0, '{cw: 16'h0004, bc: 8'd5, ec: 16'd0, pass: 1'b1, ovl: 1'b0, ovf: 1'b0});
    @(negedge clk);
    chk("s1_busy", busy1, 1'b1);
    cyc(1);
    pair(1'b1, 1'b0, 114);
    for (int k = 0; k < 4; k++) pair(1'b0, 1'b0, 114);
    end_frame(1'b0, "s1");
    cyc(3);
    chk("s1_pass_held", {pass1, rv1, busy1}, 3'b100);

    // 2: sr_out stuck at 0
    stuck = 1'b1;
    start_frame(1'b0, '{cw: 16'h0000, bc: 8'd5, ec: 16'd1, pass: 1'b0, ovl: 1'b0, ovf: 1'b0});
    @(negedge clk);
    chk("s2_pass_cleared", pass1, 1'b0);
    cyc(1);
    pair(1'b1, 1'b0, 114);
    for (int k = 0; k < 4; k++) pair(1'b0, 1'b0, 114);
    end_frame(1'b0, "s2");
    stuck = 1'b0;

    // 3: phi1/phi2 overlap for two cycles during pulse 2
    start_frame(1'b0, '{cw: 16'h0004, bc: 8'd5, ec: 16'd2, pass: 1'b0, ovl: 1'b1, ovf: 1'b0});
    pair(1'b1, 1'b0, 114);
    pair(1'b0, 1'b1, 114);
    for (int k = 0; k < 3; k++) pair(1'b0, 1'b0, 114);
    end_frame(1'b0, "s3");

    // 4: frame ends shortly after the 4th phi2 edge, pending sample dropped
    start_frame(1'b0, '{cw: 16'h0001, bc: 8'd3, ec: 16'd0, pass: 1'b1, ovl: 1'b0, ovf: 1'b0});
    pair(1'b1, 1'b0, 114);
    pair(1'b0, 1'b0, 114);
    pair(1'b0, 1'b0, 114);
    pair(1'b0, 1'b0, 10);
    end_frame(1'b0, "s4");

    // 5: reset mid-frame after the 2nd sample
    chain = '0;
    sr_out = 1'b0;
    fa = 1'b1;
    cyc(3);
    pair(1'b1, 1'b0, 114);
    pair(1'b0, 1'b0, 114);
    chk("s5_pre_reset_bits", bc1, 8'd2);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    @(negedge clk);
    chk("s5_reset_outputs", {cw1, bc1, ec1, rv1, pass1, ovl1, ovf1}, '0);
    chk("s5_reset_busy", busy1, 1'b0);
    cyc(1);
    pair(1'b0, 1'b0, 114);
    fa = 1'b0;
    nrv = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rv1 || busy1) nrv++;
    end
    chk("s5_no_result_after_reset", nrv, 0);
    cyc(1);
    start_frame(1'b0, '{cw: 16'h0004, bc: 8'd5, ec: 16'd0, pass: 1'b1, ovl: 1'b0, ovf: 1'b0});
    pair(1'b1, 1'b0, 114);
    for (int k = 0; k < 4; k++) pair(1'b0, 1'b0, 114);
    end_frame(1'b0, "s5b");

    // 6: 4-bit capture word, six samples
    start_frame(1'b1, '{cw: 16'h0002, bc: 8'd4, ec: 16'd0, pass: 1'b1, ovl: 1'b0, ovf: 1'b1});
    pair(1'b1, 1'b0, 114);
    for (int k = 0; k < 5; k++) pair(1'b0, 1'b0, 114);
    end_frame(1'b1, "s6");

    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
